// File: rtl/fifo_rd_arbiter.sv
// Read-side round-robin scheduler for several async FIFOs sharing one read clock.
// Pops the granted FIFO in bursts and forwards the words to a registered valid/ready output.
module fifo_rd_arbiter #(
  parameter int NUM_CH = 4,
  parameter int DSIZE  = 8,
  parameter int BURST  = 4
) (
  input  logic                        rclk,
  input  logic                        rrst,
  input  logic [NUM_CH-1:0]           ch_en,
  input  logic [NUM_CH-1:0]           ch_rempty,
  input  logic [NUM_CH*DSIZE-1:0]     ch_rdata,
  output logic [NUM_CH-1:0]           ch_rinc,
  output logic                        out_valid,
  output logic [DSIZE-1:0]            out_data,
  output logic [$clog2(NUM_CH)-1:0]   out_ch,
  input  logic                        out_ready,
  output logic [$clog2(NUM_CH)-1:0]   grant_ch,
  output logic                        busy
);

  localparam int CW  = $clog2(NUM_CH);
  localparam int BCW = $clog2(BURST + 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t            r_state;
  state_t            w_nextState;
  logic [CW-1:0]     r_rrLast;
  logic [CW-1:0]     r_grantCh;
  logic [BCW-1:0]    r_burstCnt;
  logic              r_outValid;
  logic [DSIZE-1:0]  r_outData;
  logic [CW-1:0]     r_outCh;

  logic [NUM_CH-1:0] w_req;
  logic              w_load;
  logic              w_pop;
  logic              w_release;
  logic              w_any;
  logic [CW-1:0]     w_winner;
  logic [DSIZE-1:0]  w_grantData;

  assign w_req       = ch_en & ~ch_rempty;
  assign w_load      = ~r_outValid | out_ready;
  assign w_grantData = ch_rdata[int'(r_grantCh)*DSIZE +: DSIZE];
  assign w_pop       = (r_state == S_GRANT) & w_req[r_grantCh] & w_load;
  // A drained or disabled channel gives up its grant without popping.
  assign w_release   = (r_state == S_GRANT) &
                       (~w_req[r_grantCh] | (w_pop & (r_burstCnt == BCW'(BURST - 1))));

  // Scan downward so the last hit is the channel closest after r_rrLast.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = NUM_CH; k >= 1; k--) begin
      if (w_req[(int'(r_rrLast) + k) % NUM_CH]) begin
        w_any    = 1'b1;
        w_winner = CW'((int'(r_rrLast) + k) % NUM_CH);
      end
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (w_any)     w_nextState = S_GRANT;
      S_GRANT: if (w_release) w_nextState = S_IDLE;
      default:                w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    ch_rinc = '0;
    busy    = (r_state == S_GRANT);
    if (!rrst && w_pop) ch_rinc[r_grantCh] = 1'b1;
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      r_rrLast   <= CW'(NUM_CH - 1);
      r_grantCh  <= '0;
      r_burstCnt <= '0;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outCh    <= '0;
    end else begin
      if (r_state == S_IDLE && w_any) begin
        r_grantCh  <= w_winner;
        r_burstCnt <= '0;
      end
      if (w_pop) begin
        r_outData  <= w_grantData;
        r_outCh    <= r_grantCh;
        r_outValid <= 1'b1;
        r_burstCnt <= r_burstCnt + BCW'(1);
      end else if (r_outValid && out_ready) begin
        r_outValid <= 1'b0;
      end
      // Clearing here keeps the counter below BURST after the final pop.
      if (w_release) begin
        r_rrLast   <= r_grantCh;
        r_burstCnt <= '0;
      end
    end
  end

  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_ch    = r_outCh;
  assign grant_ch  = r_grantCh;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: four modelled FIFOs with registered empty flags,
// a grant-vector table, and hand-written multi-cycle sequences.
module tb_fifo_rd_arbiter;

  logic        rclk;
  logic        rrst;
  logic [3:0]  ch_en;
  logic [3:0]  ch_rempty;
  logic [31:0] ch_rdata;
  logic [3:0]  ch_rinc;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
  logic [1:0]  grant_ch;
  logic        busy;

  fifo_rd_arbiter #(.NUM_CH(4), .DSIZE(8), .BURST(4)) dut (
    .rclk(rclk), .rrst(rrst), .ch_en(ch_en), .ch_rempty(ch_rempty), .ch_rdata(ch_rdata),
    .ch_rinc(ch_rinc), .out_valid(out_valid), .out_data(out_data), .out_ch(out_ch),
    .out_ready(out_ready), .grant_ch(grant_ch), .busy(busy)
  );

  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  // FIFO model: read pointer advances on the pop edge, so empty behaves as a registered flag.
  logic [7:0] tbMem [4][256];
  logic [7:0] tbRd [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0] tbWr [4] = '{8'd0, 8'd0, 8'd0, 8'd0};

  for (genvar g = 0; g < 4; g++) begin : gFifo
    assign ch_rempty[g]        = (tbRd[g] == tbWr[g]);
    assign ch_rdata[g*8 +: 8]  = tbMem[g][tbRd[g]];
  end

  always @(posedge rclk) begin
    for (int i = 0; i < 4; i++)
      if (ch_rinc[i]) tbRd[i] <= tbRd[i] + 8'd1;
  end

  int cyc = 0;
  int multiHot = 0;
  int popCyc[$];
  int popCh[$];
  int outData[$];
  int outCh[$];

  always @(posedge rclk) begin
    cyc = cyc + 1;
    if (!rrst) begin
      if (!$onehot0(ch_rinc)) multiHot = multiHot + 1;
      for (int i = 0; i < 4; i++) begin
        if (ch_rinc[i]) begin
          popCyc.push_back(cyc);
          popCh.push_back(i);
        end
      end
      if (out_valid && out_ready) begin
        outData.push_back(int'(out_data));
        outCh.push_back(int'(out_ch));
      end
    end
  end

  int checkCnt = 0;
  int passCnt  = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCnt = checkCnt + 1;
    if (actual === expected) passCnt = passCnt + 1;
    else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic loadWord(input int ch, input logic [7:0] data);
    tbMem[ch][tbWr[ch]] = data;
    tbWr[ch] = tbWr[ch] + 8'd1;
  endtask

  task automatic resetAndFlush();
    rrst = 1'b1;
    for (int i = 0; i < 4; i++) tbWr[i] = tbRd[i];
  endtask

  function automatic int popRel(input int idx, input int c0);
    if (idx < popCyc.size()) return popCyc[idx] - c0;
    return -1;
  endfunction

  function automatic int outAt(input int idx);
    if (idx < outData.size()) return outData[idx];
    return -1;
  endfunction

  function automatic int popsOf(input int p0, input int ch);
    int n = 0;
    for (int k = p0; k < popCh.size(); k++) if (popCh[k] == ch) n++;
    return n;
  endfunction

  function automatic int popsInWindow(input int lo, input int hi);
    int n = 0;
    for (int k = 0; k < popCyc.size(); k++) if (popCyc[k] >= lo && popCyc[k] <= hi) n++;
    return n;
  endfunction

  typedef struct {
    logic [3:0] en;
    logic [3:0] fill;
    logic       expBusy;
    logic [1:0] expGrant;
    logic [3:0] expRinc;
  } vec_t;

  vec_t vecs[6];

  // One word per filled channel, then check the first arbitration after reset release.
  task automatic applyStimulus(input vec_t v, input int n);
    resetAndFlush();
    ch_en     = v.en;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) if (v.fill[i]) loadWord(i, 8'(8'hC0 + i));
    #1;
    checkOutput($sformatf("v%0d_rstRinc", n), int'(ch_rinc), 0);
    checkOutput($sformatf("v%0d_rstBusy", n), int'(busy), 0);
    tick();
    rrst = 1'b0;
    tick();
    checkOutput($sformatf("v%0d_busy", n),  int'(busy),     int'(v.expBusy));
    checkOutput($sformatf("v%0d_grant", n), int'(grant_ch), int'(v.expGrant));
    checkOutput($sformatf("v%0d_rinc", n),  int'(ch_rinc),  int'(v.expRinc));
    checkOutput($sformatf("v%0d_valid", n), int'(out_valid), 0);
  endtask

  initial begin
    int c0, p0, o0, er, bad0, bad1, bad2;
    int expRel2[10] = '{2, 3, 4, 5, 7, 8, 9, 10, 12, 13};
    int expRel4[8]  = '{2, 3, 9, 10, 12, 13, 14, 15};

    rrst = 1'b1;
    ch_en = 4'h0;
    out_ready = 1'b1;
    tick();
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_data",  int'(out_data), 0);
    checkOutput("rst_ch",    int'(out_ch), 0);
    checkOutput("rst_grant", int'(grant_ch), 0);
    checkOutput("rst_busy",  int'(busy), 0);

    // Idle with every FIFO empty.
    ch_en = 4'hF;
    tick();
    rrst = 1'b0;
    bad0 = 0; bad1 = 0; bad2 = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ch_rinc != 4'h0) bad0++;
      if (out_valid)       bad1++;
      if (busy)            bad2++;
    end
    checkOutput("t1_rincCycles",  bad0, 0);
    checkOutput("t1_validCycles", bad1, 0);
    checkOutput("t1_busyCycles",  bad2, 0);

    vecs[0] = '{4'hF,    4'b0100, 1'b1, 2'd2, 4'b0100};
    vecs[1] = '{4'hF,    4'b1010, 1'b1, 2'd1, 4'b0010};
    vecs[2] = '{4'b1101, 4'b0110, 1'b1, 2'd2, 4'b0100};
    vecs[3] = '{4'h0,    4'b1111, 1'b0, 2'd0, 4'b0000};
    vecs[4] = '{4'hF,    4'b1000, 1'b1, 2'd3, 4'b1000};
    vecs[5] = '{4'b0111, 4'b1001, 1'b1, 2'd0, 4'b0001};
    for (int n = 0; n < 6; n++) applyStimulus(vecs[n], n);

    // Ten words in ch0 split into bursts of 4, 4, 2.
    resetAndFlush();
    ch_en = 4'hF;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) loadWord(0, 8'(8'hA0 + k));
    tick();
    p0 = popCyc.size(); o0 = outData.size();
    rrst = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 20; i++) tick();
    checkOutput("t2_popCount", popCyc.size() - p0, 10);
    for (int k = 0; k < 10; k++) checkOutput($sformatf("t2_popEdge%0d", k), popRel(p0 + k, c0), expRel2[k]);
    checkOutput("t2_outCount", outData.size() - o0, 10);
    bad0 = 0;
    for (int k = 0; k < 10; k++) begin
      checkOutput($sformatf("t2_data%0d", k), outAt(o0 + k), 'hA0 + k);
      if (o0 + k < outCh.size() && outCh[o0 + k] != 0) bad0++;
    end
    checkOutput("t2_outChNonZero", bad0, 0);
    checkOutput("t2_empty0", int'(ch_rempty[0]), 1);
    checkOutput("t2_busyEnd", int'(busy), 0);

    // All four channels full: round-robin 0,1,2,3 twice.
    resetAndFlush();
    ch_en = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 8; w++) loadWord(c, 8'(c * 16 + w));
    tick();
    p0 = popCyc.size(); o0 = outData.size();
    rrst = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    checkOutput("t3_popCount", popCyc.size() - p0, 32);
    for (int k = 0; k < 32; k++) begin
      int expCh, expW;
      expCh = (k / 4) % 4;
      expW  = (k / 16) * 4 + (k % 4);
      checkOutput($sformatf("t3_popCh%0d", k),
                  (p0 + k < popCh.size()) ? popCh[p0 + k] : -1, expCh);
      checkOutput($sformatf("t3_data%0d", k), outAt(o0 + k), expCh * 16 + expW);
    end

    // Back-pressure in the middle of a ch1 burst.
    resetAndFlush();
    ch_en = 4'hF;
    for (int k = 0; k < 8; k++) loadWord(1, 8'(8'h50 + k));
    tick();
    p0 = popCyc.size(); o0 = outData.size();
    rrst = 1'b0;
    c0 = cyc;
    tick(); tick(); tick();
    out_ready = 1'b0;
    #1;
    checkOutput("t4_stallRinc", int'(ch_rinc), 0);
    checkOutput("t4_stallBusy", int'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("t4_holdRinc%0d", i), int'(ch_rinc), 0);
      checkOutput($sformatf("t4_holdData%0d", i), int'(out_data), 'h51);
      checkOutput($sformatf("t4_holdCh%0d", i),   int'(out_ch), 1);
    end
    er = cyc;
    out_ready = 1'b1;
    #1;
    checkOutput("t4_resumeRinc", int'(ch_rinc), 'b0010);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t4_stallPops", popsInWindow(c0 + 4, er), 0);
    checkOutput("t4_popCount", popCyc.size() - p0, 8);
    for (int k = 0; k < 8; k++) checkOutput($sformatf("t4_popEdge%0d", k), popRel(p0 + k, c0), expRel4[k]);
    for (int k = 0; k < 8; k++) checkOutput($sformatf("t4_data%0d", k), outAt(o0 + k), 'h50 + k);

    // Disabled channel never served; disabling the granted one ends its burst.
    resetAndFlush();
    ch_en = 4'b1011;
    for (int k = 0; k < 4; k++) loadWord(2, 8'(8'h60 + k));
    for (int k = 0; k < 8; k++) loadWord(3, 8'(8'h70 + k));
    tick();
    p0 = popCyc.size(); o0 = outData.size();
    rrst = 1'b0;
    tick(); tick(); tick();
    ch_en = 4'b0011;
    #1;
    checkOutput("t5_rincAfterClear", int'(ch_rinc), 0);
    for (int i = 0; i < 10; i++) tick();
    checkOutput("t5_pops3", popsOf(p0, 3), 2);
    checkOutput("t5_pops2", popsOf(p0, 2), 0);
    checkOutput("t5_busy", int'(busy), 0);
    checkOutput("t5_grant", int'(grant_ch), 3);
    checkOutput("t5_outCount", outData.size() - o0, 2);
    checkOutput("t5_data0", outAt(o0), 'h70);
    checkOutput("t5_data1", outAt(o0 + 1), 'h71);

    // Reset in the middle of a burst.
    resetAndFlush();
    ch_en = 4'hF;
    for (int k = 0; k < 8; k++) loadWord(1, 8'(8'h80 + k));
    tick();
    rrst = 1'b0;
    tick(); tick();
    checkOutput("t6_preValid", int'(out_valid), 1);
    rrst = 1'b1;
    #1;
    checkOutput("t6_rstValid", int'(out_valid), 0);
    checkOutput("t6_rstRinc",  int'(ch_rinc), 0);
    checkOutput("t6_rstBusy",  int'(busy), 0);
    checkOutput("t6_rstData",  int'(out_data), 0);
    loadWord(0, 8'h90);
    loadWord(0, 8'h91);
    tick();
    rrst = 1'b0;
    tick();
    checkOutput("t6_grant", int'(grant_ch), 0);
    checkOutput("t6_busy",  int'(busy), 1);
    checkOutput("t6_rinc",  int'(ch_rinc), 'b0001);
    tick();
    checkOutput("t6_data", int'(out_data), 'h90);
    checkOutput("t6_ch",   int'(out_ch), 0);

    for (int i = 0; i < 5; i++) tick();
    checkOutput("multiHotRinc", multiHot, 0);

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
